truth_table_sequencer: RTL and testbench
========================================

// Module: truth_table_sequencer
// PURPOSE
//  Controller that sequences a combinational gate-level unit (XNOR/mux, NAND-tree style)
//  through every input combination, waits a settle time and captures each output into a
//  packed truth table. Replaces hand-written per-vector testbench stimulus.
//  Sits between a host (start/done) and the unit (vec_out drives inputs, func_in = outputs).
// PARAMETERS
//  N_IN    3  number of unit inputs; 2**N_IN vectors scanned (1..6)
//  N_OUT   2  number of unit outputs captured per vector (1..4)
//  SETTLE  2  cycles vec_out is held before sampling (>=1)
// PORTS
//  clk        in   1                clock, rising edge
//  rst_n      in   1                asynchronous reset, active low
//  start      in   1                begin scan; sampled in IDLE only
//  abort      in   1                synchronous cancel of running scan
//  func_in    in   N_OUT            unit outputs (bit0 = sa, bit1 = sb, ...)
//  vec_out    out  N_IN             unit inputs; MSB = a, ..., LSB = c
//  busy       out  1                high in WAIT/SAMPLE
//  done       out  1                one-cycle pulse at scan completion
//  table_out  out  N_OUT*2**N_IN    bit [o*2**N_IN + v] = output o at vector v
//  table_vld  out  1                table_out complete and stable
// BEHAVIOUR
//  - Reset (async, any state): state IDLE; vec_out, busy, done, table_out, table_vld,
//    cnt all 0. Reset mid-scan discards partial table.
//  - States: IDLE, WAIT, SAMPLE, DONE.
//  - IDLE: start=1 -> WAIT; vec_out<=0, cnt<=SETTLE-1, table_out<=0, table_vld<=0.
//  - WAIT: cnt decrements; cnt==0 -> SAMPLE. WAIT lasts exactly SETTLE cycles.
//  - SAMPLE (1 cycle): table_out[o*2**N_IN+vec_out] <= func_in[o] for all o.
//    vec_out==2**N_IN-1 -> DONE; else vec_out<=vec_out+1, cnt<=SETTLE-1, -> WAIT.
//  - DONE (1 cycle): done=1, table_vld<=1, -> IDLE. vec_out held at last vector.
//  - Latency: SETTLE+1 cycles per vector; done high 2**N_IN*(SETTLE+1) clocks after
//    the edge sampling start (24 for defaults).
//  - start while busy or in DONE: ignored. start and abort together in IDLE: abort wins.
//  - abort in WAIT/SAMPLE: -> IDLE next edge; vec_out<=0; no done; table_vld stays 0;
//    partial table_out retained. abort in IDLE/DONE: no effect.
//  - vec_out never wraps: scan stops at last vector; no other vector is driven while busy.
//  - table_out changes only in SAMPLE or on start; stable while table_vld=1.
// CONFIGURATION
//  TTS_EXPECT_CHECK_EN defined: extra ports
//    expected   in   N_OUT*2**N_IN  golden table, same packing, must be stable while busy
//    mismatch   out  1              sticky; set in SAMPLE when any captured bit != golden
//    err_cnt    out  8              mismatching bits, saturates at 255
//    both cleared on start and reset; valid with table_vld.
//  Undefined: ports and compare logic absent; base behaviour identical.
// TESTING
//  1 Defaults, func_in from XNOR(a,b)/NAND-tree units, pulse start -> done 24 clocks
//    later, table_out=16'h2EC3, table_vld=1, busy low same cycle as done.
//  2 SETTLE=1 vs 4, check vec_out holds each value exactly SETTLE+1 cycles, sequence 0..7.
//  3 abort during vector 5 WAIT -> IDLE next edge, vec_out=0, no done, table_vld=0.
//  4 rst_n low during vector 3 -> all outputs 0 immediately (async); new start rescans.
//  5 start held high throughout -> back-to-back scans, gap of exactly 1 DONE + 1 IDLE
//    cycle; extra start pulses while busy do not restart.
//  6 TTS_EXPECT_CHECK_EN, expected=16'h2EC3 -> mismatch=0, err_cnt=0; expected=16'h2EC2
//    -> mismatch=1, err_cnt=1.

Source files
------------

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer
//   Walks a combinational unit through all 2**N_IN input vectors. Each vector is held for
//   SETTLE cycles, then the unit outputs are captured into a packed truth table.
//
//   Ports:
//     clk, rst_n   clock (rising edge), asynchronous active-low reset
//     start        begin a scan (honoured in IDLE only)
//     abort        cancel a running scan; wins over start in IDLE
//     func_in      unit outputs, bit o = output o
//     vec_out      unit inputs (MSB = a ... LSB = c)
//     busy         high while a scan is running (WAIT/SAMPLE)
//     done         one-cycle pulse when a scan completes
//     table_out    bit [o*2**N_IN + v] = output o at vector v
//     table_vld    table_out complete and stable
//
//   Optional feature, macro TTS_EXPECT_CHECK_EN: adds input expected (golden table, same
//   packing) and outputs mismatch (sticky) and err_cnt (saturating count of bad bits).
module truth_table_sequencer #(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned N_OUT  = 2,
  parameter int unsigned SETTLE = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [N_OUT-1:0]              func_in,
`ifdef TTS_EXPECT_CHECK_EN
  input  logic [N_OUT*(2**N_IN)-1:0]    expected,
  output logic                          mismatch,
  output logic [7:0]                    err_cnt,
`endif
  output logic [N_IN-1:0]               vec_out,
  output logic                          busy,
  output logic                          done,
  output logic [N_OUT*(2**N_IN)-1:0]    table_out,
  output logic                          table_vld
);

  localparam int unsigned NVec = 2**N_IN;
  localparam int unsigned TblW = N_OUT * NVec;
  // Counter only ever holds values up to SETTLE-1.
  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [N_IN-1:0] LastVec = N_IN'(NVec - 1);
  localparam logic [CntW-1:0] CntInit = CntW'(SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StWait, StSample, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [TblW-1:0]   table_q, table_d;
  logic              vld_q, vld_d;

`ifdef TTS_EXPECT_CHECK_EN
  logic              mismatch_q, mismatch_d;
  logic [7:0]        err_q, err_d;
  logic [8:0]        nbad;
  logic [8:0]        err_sum;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    table_d = table_q;
    vld_d   = vld_q;
`ifdef TTS_EXPECT_CHECK_EN
    mismatch_d = mismatch_q;
    err_d      = err_q;
    nbad       = '0;
    err_sum    = '0;
`endif

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StWait;
          vec_d   = '0;
          cnt_d   = CntInit;
          table_d = '0;
          vld_d   = 1'b0;
`ifdef TTS_EXPECT_CHECK_EN
          mismatch_d = 1'b0;
          err_d      = '0;
`endif
        end
      end

      StWait: begin
        if (abort) begin
          state_d = StIdle;
          vec_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StSample: begin
        if (abort) begin
          // Abort takes precedence over the capture of this vector.
          state_d = StIdle;
          vec_d   = '0;
        end else begin
          // Decode vec_q against constants so every table index stays static.
          for (int unsigned v = 0; v < NVec; v++) begin
            if (vec_q == N_IN'(v)) begin
              for (int unsigned o = 0; o < N_OUT; o++) begin
                table_d[o*NVec + v] = func_in[o];
`ifdef TTS_EXPECT_CHECK_EN
                if (func_in[o] != expected[o*NVec + v]) nbad = nbad + 9'd1;
`endif
              end
            end
          end
`ifdef TTS_EXPECT_CHECK_EN
          err_sum = {1'b0, err_q} + nbad;
          err_d   = (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
          if (nbad != '0) mismatch_d = 1'b1;
`endif
          if (vec_q == LastVec) begin
            // vec_out stays on the last vector; it never wraps.
            state_d = StDone;
          end else begin
            vec_d   = vec_q + N_IN'(1);
            cnt_d   = CntInit;
            state_d = StWait;
          end
        end
      end

      StDone: begin
        vld_d   = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      vec_q   <= '0;
      table_q <= '0;
      vld_q   <= 1'b0;
`ifdef TTS_EXPECT_CHECK_EN
      mismatch_q <= 1'b0;
      err_q      <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      table_q <= table_d;
      vld_q   <= vld_d;
`ifdef TTS_EXPECT_CHECK_EN
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
`endif
    end
  end

  assign vec_out   = vec_q;
  assign busy      = (state_q == StWait) || (state_q == StSample);
  assign done      = (state_q == StDone);
  assign table_out = table_q;
  assign table_vld = vld_q;
`ifdef TTS_EXPECT_CHECK_EN
  assign mismatch  = mismatch_q;
  assign err_cnt   = err_q;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: default instance (SETTLE=2) plus SETTLE=1 and SETTLE=4
// instances sharing one start. Unit model: sa = XNOR(a,b), sb = NAND-tree style function.
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default instance.
  logic        start_a, abort_a;
  logic [1:0]  func_a;
  logic [2:0]  vec_a;
  logic        busy_a, done_a, vld_a;
  logic [15:0] table_a;

  // SETTLE=1 and SETTLE=4 instances.
  logic        start_b, abort_b;
  logic [1:0]  func_1, func_4;
  logic [2:0]  vec_1, vec_4;
  logic        busy_1, busy_4, done_1, done_4, vld_1, vld_4;
  logic [15:0] table_1, table_4;

`ifdef TTS_EXPECT_CHECK_EN
  logic [15:0] expected_a;
  logic        mismatch_a, mismatch_1, mismatch_4;
  logic [7:0]  err_a, err_1, err_4;
  logic [15:0] expected_b;
`endif

  // a = v[2], b = v[1], c = v[0]; returns {sb, sa}.
  function automatic logic [1:0] unit_model(input logic [2:0] v);
    logic a, b, c, sa, sb;
    a  = v[2];
    b  = v[1];
    c  = v[0];
    sa = ~(a ^ b);
    sb = ~(~(~a & (b | c)) & ~(a & ~b & c));
    return {sb, sa};
  endfunction

  // Table after capturing vectors 0..nvec-1 (uncaptured bits are 0).
  function automatic logic [15:0] model_table(input int nvec);
    logic [15:0] t;
    logic [1:0]  m;
    t = '0;
    for (int v = 0; v < nvec; v++) begin
      m        = unit_model(3'(v));
      t[v]     = m[0];
      t[8 + v] = m[1];
    end
    return t;
  endfunction

  assign func_a = unit_model(vec_a);
  assign func_1 = unit_model(vec_1);
  assign func_4 = unit_model(vec_4);

  truth_table_sequencer #(.N_IN(3), .N_OUT(2), .SETTLE(2)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_a),
    .abort     (abort_a),
    .func_in   (func_a),
`ifdef TTS_EXPECT_CHECK_EN
    .expected  (expected_a),
    .mismatch  (mismatch_a),
    .err_cnt   (err_a),
`endif
    .vec_out   (vec_a),
    .busy      (busy_a),
    .done      (done_a),
    .table_out (table_a),
    .table_vld (vld_a)
  );

  truth_table_sequencer #(.N_IN(3), .N_OUT(2), .SETTLE(1)) u_dut_1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_b),
    .abort     (abort_b),
    .func_in   (func_1),
`ifdef TTS_EXPECT_CHECK_EN
    .expected  (expected_b),
    .mismatch  (mismatch_1),
    .err_cnt   (err_1),
`endif
    .vec_out   (vec_1),
    .busy      (busy_1),
    .done      (done_1),
    .table_out (table_1),
    .table_vld (vld_1)
  );

  truth_table_sequencer #(.N_IN(3), .N_OUT(2), .SETTLE(4)) u_dut_4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_b),
    .abort     (abort_b),
    .func_in   (func_4),
`ifdef TTS_EXPECT_CHECK_EN
    .expected  (expected_b),
    .mismatch  (mismatch_4),
    .err_cnt   (err_4),
`endif
    .vec_out   (vec_4),
    .busy      (busy_4),
    .done      (done_4),
    .table_out (table_4),
    .table_vld (vld_4)
  );

  logic [15:0] sb_q[$];
  logic [2:0]  qv1[$];
  logic [2:0]  qv4[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full scan on the default instance: latency, busy, table, table_vld.
  task automatic scan_a(input string tag);
    int n;
    logic [15:0] exp_t;
    sb_q.push_back(model_table(8));
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    while (done_a !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (n !== 24) begin bad++; $display("FAIL %s_latency got=%0d want=24", tag, n); end
    total++;
    if (busy_a !== 1'b0) begin bad++; $display("FAIL %s_busy_at_done got=%b want=0", tag, busy_a); end
    exp_t = sb_q.pop_front();
    total++;
    if (table_a !== exp_t) begin
      bad++; $display("FAIL %s_table got=%h want=%h", tag, table_a, exp_t);
    end
    tick();
    total++;
    if (vld_a !== 1'b1) begin bad++; $display("FAIL %s_table_vld got=%b want=1", tag, vld_a); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++;
    if (vec_a !== 3'd0) begin bad++; $display("FAIL reset_vec got=%0d want=0", vec_a); end
    total++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      bad++; $display("FAIL reset_busy_done got=%b%b want=00", busy_a, done_a);
    end
    total++;
    if (table_a !== 16'h0 || vld_a !== 1'b0) begin
      bad++; $display("FAIL reset_table got=%h/%b want=0000/0", table_a, vld_a);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_scan();
    scan_a("scan");
    total++;
    if (table_a !== 16'h2EC3) begin
      bad++; $display("FAIL scan_golden got=%h want=2ec3", table_a);
    end
    total++;
    if (vec_a !== 3'd7) begin bad++; $display("FAIL scan_vec_held got=%0d want=7", vec_a); end
  endtask

  task automatic test_settle();
    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < 2; k++) qv1.push_back(3'(v));
      for (int k = 0; k < 5; k++) qv4.push_back(3'(v));
    end
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (!busy_1 && !busy_4) break;
      if (busy_1) begin
        total++;
        if (qv1.size() == 0) begin
          bad++; $display("FAIL settle1_too_long vec=%0d", vec_1);
        end else if (vec_1 !== qv1[0]) begin
          bad++; $display("FAIL settle1_vec got=%0d want=%0d", vec_1, qv1[0]);
          void'(qv1.pop_front());
        end else begin
          void'(qv1.pop_front());
        end
      end
      if (busy_4) begin
        total++;
        if (qv4.size() == 0) begin
          bad++; $display("FAIL settle4_too_long vec=%0d", vec_4);
        end else if (vec_4 !== qv4[0]) begin
          bad++; $display("FAIL settle4_vec got=%0d want=%0d", vec_4, qv4[0]);
          void'(qv4.pop_front());
        end else begin
          void'(qv4.pop_front());
        end
      end
      tick();
    end
    total++;
    if (qv1.size() != 0) begin bad++; $display("FAIL settle1_short left=%0d want=0", qv1.size()); end
    total++;
    if (qv4.size() != 0) begin bad++; $display("FAIL settle4_short left=%0d want=0", qv4.size()); end
    total++;
    if (table_1 !== 16'h2EC3 || table_4 !== 16'h2EC3) begin
      bad++; $display("FAIL settle_tables got=%h/%h want=2ec3", table_1, table_4);
    end
  endtask

  task automatic test_abort();
    int n, ndone;
    logic [15:0] exp_t;
    // start and abort together in IDLE: abort wins.
    start_a = 1'b1;
    abort_a = 1'b1;
    tick();
    start_a = 1'b0;
    abort_a = 1'b0;
    total++;
    if (busy_a !== 1'b0) begin bad++; $display("FAIL abort_wins got busy=%b want=0", busy_a); end

    sb_q.push_back(model_table(5));
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    while (vec_a !== 3'd5 && n < 100) begin tick(); n++; end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    total++;
    if (busy_a !== 1'b0 || vec_a !== 3'd0) begin
      bad++; $display("FAIL abort_idle got busy=%b vec=%0d want 0/0", busy_a, vec_a);
    end
    exp_t = sb_q.pop_front();
    total++;
    if (table_a !== exp_t) begin
      bad++; $display("FAIL abort_partial got=%h want=%h", table_a, exp_t);
    end
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      if (done_a === 1'b1) ndone++;
      tick();
    end
    total++;
    if (ndone != 0 || vld_a !== 1'b0) begin
      bad++; $display("FAIL abort_no_done got done=%0d vld=%b want 0/0", ndone, vld_a);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    while (vec_a !== 3'd3 && n < 100) begin tick(); n++; end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (vec_a !== 3'd0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      bad++; $display("FAIL rstmid_ctrl got vec=%0d busy=%b done=%b want 0", vec_a, busy_a, done_a);
    end
    total++;
    if (table_a !== 16'h0 || vld_a !== 1'b0) begin
      bad++; $display("FAIL rstmid_table got=%h/%b want=0000/0", table_a, vld_a);
    end
    #2 rst_n = 1'b1;
    scan_a("rescan");
  endtask

  task automatic test_back_to_back();
    int n;
    int prev;
    bit mono_ok;
    logic [15:0] exp_t;
    sb_q.push_back(model_table(8));
    sb_q.push_back(model_table(8));
    start_a = 1'b1;
    tick();
    n = 0;
    while (done_a !== 1'b1 && n < 200) begin tick(); n++; end
    total++;
    if (n !== 24) begin bad++; $display("FAIL b2b_first got=%0d want=24", n); end
    exp_t = sb_q.pop_front();
    total++;
    if (table_a !== exp_t) begin bad++; $display("FAIL b2b_table1 got=%h want=%h", table_a, exp_t); end
    tick();
    total++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      bad++; $display("FAIL b2b_gap got busy=%b done=%b want 0/0", busy_a, done_a);
    end
    tick();
    total++;
    if (busy_a !== 1'b1 || vec_a !== 3'd0) begin
      bad++; $display("FAIL b2b_restart got busy=%b vec=%0d want 1/0", busy_a, vec_a);
    end
    n = 2;
    prev = 0;
    mono_ok = 1'b1;
    while (done_a !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (busy_a === 1'b1) begin
        if (int'(vec_a) < prev) mono_ok = 1'b0;
        prev = int'(vec_a);
      end
    end
    start_a = 1'b0;
    total++;
    if (n !== 26) begin bad++; $display("FAIL b2b_period got=%0d want=26", n); end
    total++;
    if (!mono_ok) begin bad++; $display("FAIL b2b_restart_while_busy got=nonmonotonic want=monotonic"); end
    exp_t = sb_q.pop_front();
    total++;
    if (table_a !== exp_t) begin bad++; $display("FAIL b2b_table2 got=%h want=%h", table_a, exp_t); end
    tick();
    tick();
  endtask

`ifdef TTS_EXPECT_CHECK_EN
  task automatic test_expect();
    expected_a = 16'h2EC3;
    scan_a("exp_good");
    total++;
    if (mismatch_a !== 1'b0 || err_a !== 8'd0) begin
      bad++; $display("FAIL exp_good got mis=%b err=%0d want 0/0", mismatch_a, err_a);
    end
    expected_a = 16'h2EC2;
    scan_a("exp_bad");
    total++;
    if (mismatch_a !== 1'b1 || err_a !== 8'd1) begin
      bad++; $display("FAIL exp_bad got mis=%b err=%0d want 1/1", mismatch_a, err_a);
    end
  endtask
`endif

  initial begin
    start_a = 1'b0;
    abort_a = 1'b0;
    start_b = 1'b0;
    abort_b = 1'b0;
`ifdef TTS_EXPECT_CHECK_EN
    expected_a = 16'h2EC3;
    expected_b = 16'h2EC3;
`endif
    test_reset();
    test_scan();
    test_settle();
    test_abort();
    test_reset_mid();
    test_back_to_back();
`ifdef TTS_EXPECT_CHECK_EN
    test_expect();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
